// File: rtl/popcount8_enum.sv
// Enumerates, in ascending order, every 8-bit word whose population count equals a requested K.
// Each word is streamed over a valid/ready handshake; a request with K > 8 is rejected with a one-cycle err pulse.
`timescale 1ns/1ps
module popcount8_enum (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] K,
    input  logic       start_valid,
    output logic       start_ready,
    output logic [7:0] O,
    output logic       O_valid,
    input  logic       O_ready,
    output logic [6:0] O_idx,
    output logic       last,
    output logic       err
);
    localparam int unsigned W    = 8;
    localparam int unsigned KW   = 4;
    localparam int unsigned IDXW = 7;

    typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [KW-1:0]   k_q;
    logic [2:0]      low_pos;
    logic [W-1:0]    low_bit;
    logic [W:0]      sum9;
    logic [W:0]      ripple;
    logic [W-1:0]    next_word;

    // Smallest word with k ones: the k low bits set.
    function automatic logic [W-1:0] first_word(input logic [KW-1:0] k);
        return W'((16'd1 << k) - 16'd1);
    endfunction

    // Largest word with k ones: the k high bits set; k = 0 gives 0x00.
    function automatic logic [W-1:0] high_word(input logic [KW-1:0] k);
        return W'(16'h00FF << (4'd8 - k));
    endfunction

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_valid && (K <= 4'd8)) state_d = EMIT;
            EMIT: if (O_valid && O_ready && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state only.
    always_comb begin
        start_ready = 1'b0;
        start_ready = (state_q == IDLE);
    end

    // Gosper step: next larger word with the same popcount; the sum is kept 9 bits wide.
    always_comb begin
        low_pos = 3'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (O[i]) low_pos = 3'(i);
        end
        low_bit   = O & (~O + W'(1));
        sum9      = {1'b0, O} + {1'b0, low_bit};
        ripple    = (({1'b0, O} ^ sum9) >> 2) >> low_pos;
        next_word = W'(ripple | sum9);
    end

    // Registered stream outputs and captured K.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            O       <= '0;
            O_valid <= 1'b0;
            O_idx   <= '0;
            last    <= 1'b0;
            err     <= 1'b0;
            k_q     <= '0;
        end else begin
            err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        if (K <= 4'd8) begin
                            k_q     <= K;
                            O       <= first_word(K);
                            O_idx   <= '0;
                            last    <= (first_word(K) == high_word(K));
                            O_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (O_ready) begin
                        if (last) begin
                            O_valid <= 1'b0;
                            last    <= 1'b0;
                        end else begin
                            O     <= next_word;
                            O_idx <= O_idx + IDXW'(1);
                            last  <= (next_word == high_word(k_q));
                        end
                    end
                end
                default: O_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_popcount8_enum.sv
// Randomized self-checking bench for popcount8_enum against an exhaustive ascending-scan model.
`timescale 1ns/1ps
module tb_popcount8_enum;
    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] K;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] O;
    logic       O_valid;
    logic       O_ready;
    logic [6:0] O_idx;
    logic       last;
    logic       err;

    int errors = 0;
    int checks = 0;

    popcount8_enum dut (
        .CLK(CLK), .RESET(RESET), .K(K), .start_valid(start_valid),
        .start_ready(start_ready), .O(O), .O_valid(O_valid), .O_ready(O_ready),
        .O_idx(O_idx), .last(last), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int popcnt(input logic [7:0] v);
        int n = 0;
        for (int b = 0; b < 8; b++) n += int'(v[b]);
        return n;
    endfunction

    // Model: every 8-bit value with popcount k, scanned in ascending order.
    task automatic build_list(input int k, output logic [7:0] lst[$]);
        lst = {};
        for (int v = 0; v < 256; v++) if (popcnt(8'(v)) == k) lst.push_back(8'(v));
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        checks++;
        if (start_ready !== 1'b1 || O_valid !== 1'b0 || O !== 8'h00 || O_idx !== 7'd0 ||
            last !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b O=%h idx=%0d last=%b err=%b want 1 0 00 0 0 0",
                     start_ready, O_valid, O, O_idx, last, err);
        end
    endtask

    task automatic test_enum(input int k, input int stall_pct);
        logic [7:0] exp[$];
        int n = 0;
        build_list(k, exp);
        K = 4'(k);
        start_valid = 1'b1;
        O_ready = 1'b0;
        tick();
        start_valid = 1'b0;
        for (int cyc = 0; cyc < 4000 && n < exp.size(); cyc++) begin
            checks++;
            if (O_valid !== 1'b1 || O !== exp[n] || O_idx !== 7'(n) ||
                last !== (n == exp.size() - 1)) begin
                errors++;
                $display("FAIL enum k=%0d word %0d: vld=%b O=%h idx=%0d last=%b want 1 %h %0d %b",
                         k, n, O_valid, O, O_idx, last, exp[n], n, (n == exp.size() - 1));
            end
            checks++;
            if (popcnt(O) != k) begin
                errors++;
                $display("FAIL popcount k=%0d: O=%h has %0d ones", k, O, popcnt(O));
            end
            O_ready = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
            tick();
            if (O_ready) n++;
        end
        O_ready = 1'b0;
        checks++;
        if (n != exp.size()) begin
            errors++;
            $display("FAIL enum_count k=%0d: got %0d words want %0d", k, n, exp.size());
        end
        checks++;
        if (O_valid !== 1'b0 || last !== 1'b0 || start_ready !== 1'b1 ||
            O !== exp[exp.size()-1] || O_idx !== 7'(exp.size() - 1)) begin
            errors++;
            $display("FAIL enum_end k=%0d: vld=%b last=%b rdy=%b O=%h idx=%0d want 0 0 1 %h %0d",
                     k, O_valid, last, start_ready, O, O_idx, exp[exp.size()-1], exp.size() - 1);
        end
    endtask

    task automatic test_err();
        K = 4'($urandom_range(15, 9));
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || O_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse K=%0d: err=%b vld=%b rdy=%b want 1 0 1",
                     K, err, O_valid, start_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (err !== 1'b0 || O_valid !== 1'b0 || start_ready !== 1'b1) begin
                errors++;
                $display("FAIL err_after: err=%b vld=%b rdy=%b want 0 0 1", err, O_valid, start_ready);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp[$];
        build_list(3, exp);
        K = 4'd3;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        O_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (O_valid !== 1'b1 || O !== exp[n] || O_idx !== 7'(n)) begin
                errors++;
                $display("FAIL abort_pre word %0d: vld=%b O=%h idx=%0d want 1 %h %0d",
                         n, O_valid, O, O_idx, exp[n], n);
            end
            tick();
        end
        RESET = 1'b1;
        start_valid = 1'b1;
        K = 4'd1;
        tick();
        RESET = 1'b0;
        start_valid = 1'b0;
        O_ready = 1'b0;
        checks++;
        if (O_valid !== 1'b0 || start_ready !== 1'b1 || O !== 8'h00 || O_idx !== 7'd0) begin
            errors++;
            $display("FAIL abort: vld=%b rdy=%b O=%h idx=%0d want 0 1 00 0",
                     O_valid, start_ready, O, O_idx);
        end
        tick();
        checks++;
        if (O_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_capture: vld=%b want 0", O_valid);
        end
        test_enum(1, 30);
    endtask

    task automatic test_start_ignored();
        logic [7:0] exp[$];
        build_list(1, exp);
        K = 4'd1;
        start_valid = 1'b1;
        tick();
        K = 4'd5;
        O_ready = 1'b1;
        for (int n = 0; n < exp.size(); n++) begin
            checks++;
            if (O_valid !== 1'b1 || O !== exp[n] || O_idx !== 7'(n) || start_ready !== 1'b0) begin
                errors++;
                $display("FAIL ignore word %0d: vld=%b O=%h idx=%0d rdy=%b want 1 %h %0d 0",
                         n, O_valid, O, O_idx, start_ready, exp[n], n);
            end
            tick();
        end
        checks++;
        if (O_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_end: vld=%b rdy=%b want 0 1", O_valid, start_ready);
        end
        tick();
        start_valid = 1'b0;
        checks++;
        if (O_valid !== 1'b1 || O !== 8'h1F || O_idx !== 7'd0) begin
            errors++;
            $display("FAIL ignore_capture: vld=%b O=%h idx=%0d want 1 1f 0", O_valid, O, O_idx);
        end
        for (int i = 0; i < 200; i++) begin
            if (O_valid && last) begin
                tick();
                break;
            end
            tick();
        end
        O_ready = 1'b0;
        checks++;
        if (O_valid !== 1'b0 || O !== 8'hF8 || O_idx !== 7'd55) begin
            errors++;
            $display("FAIL k5_drain: vld=%b O=%h idx=%0d want 0 f8 55", O_valid, O, O_idx);
        end
    endtask

    initial begin
        RESET = 1'b1;
        K = 4'd0;
        start_valid = 1'b0;
        O_ready = 1'b0;
        test_reset();
        test_enum(0, 0);
        test_enum(2, 0);
        test_enum(8, 0);
        test_err();
        test_enum(4, 50);
        test_enum(6, 20);
        test_reset_abort();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
